// File: rtl/ahb_wait_slave.sv
// ahb_wait_slave: AHB-Lite subordinate backed by a word-addressed on-chip memory.
// OKAY transfers are stretched by WAIT_STATES wait cycles. Illegal transfers get the
// standard two-cycle ERROR response and never wait. Words at or above RO_BASE are
// read-only.
//
// Ports:
//   HCLK, HRESET        clock (rising edge), asynchronous active-high reset
//   HSEL, HREADY        decoder select and bus ready from the mux
//   HADDR, HWRITE,      address-phase controls, latched on accept
//   HSIZE, HTRANS
//   HBURST              ignored; every beat is handled independently
//   HWDATA              write data, valid in the data phase
//   HRDATA              read data; zero except during a read's final data cycle
//   HREADYOUT, HRESP    slave ready and response, decoded from registered state
module ahb_wait_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned RO_BASE     = 32'hF0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    // Not reset; the bench preloads it hierarchically.
    logic [DATA_WIDTH-1:0] DATA_MEM [0:MEM_DEPTH-1];

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;

    logic            accept;
    logic [IdxW-1:0] req_idx;
    logic            req_err;
    logic [3:0]      byte_en;
    logic            mem_we;

    // Upper address bits alias; burst type and HTRANS[0] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0], HADDR[ADDR_WIDTH-1:IdxW+2]};

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign req_idx = HADDR[IdxW+1:2];

    always_comb begin
        req_err = 1'b0;
        if (HSIZE > 3'd2)                                  req_err = 1'b1;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))      req_err = 1'b1;
        if ((HSIZE == 3'd1) && HADDR[0])                   req_err = 1'b1;
        if (HWRITE && (32'(req_idx) >= RO_BASE))           req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        unique case (state_q)
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StData;
                end
            end
            StErr1: begin
                state_d = StErr2;
            end
            // StIdle, StData and StErr2 all present HREADYOUT=1, so each may take
            // the next address phase.
            default: begin
                state_d = StIdle;
                if (accept) begin
                    idx_d   = req_idx;
                    off_d   = HADDR[1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (req_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Little-endian lane enables; only legal sizes ever reach StData.
    always_comb begin
        unique case (size_q)
            3'd0:    byte_en = 4'b0001 << off_q;
            3'd1:    byte_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Gate on HRESET so a write whose closing edge coincides with reset is dropped.
    assign mem_we = (state_q == StData) && write_q && !HRESET;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    DATA_MEM[idx_q][8*k +: 8] <= HWDATA[8*k +: 8];
                end
            end
        end
    end

    assign HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
    assign HRESP     = (state_q == StErr1) || (state_q == StErr2);
    assign HRDATA    = ((state_q == StData) && !write_q) ? DATA_MEM[idx_q] : '0;

endmodule

// File: tb/tb_ahb_wait_slave.sv
// Bench for ahb_wait_slave: one instance with two wait states (d=0) and one with none
// (d=1) share a bus; a word-array reference model predicts responses and memory.
module tb_ahb_wait_slave;

    logic        HCLK;
    logic        HRESET;
    logic        hsel;
    logic        dsel;
    logic        hwrite;
    logic        hready_block;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;

    logic [31:0] rdata2, rdata0;
    logic        rdy2, rdy0, resp2, resp0;
    logic        hsel2, hsel0, hready2, hready0;
    logic [31:0] o_rdata;
    logic        o_rdy, o_resp;

    assign hsel2   = hsel & ~dsel;
    assign hsel0   = hsel & dsel;
    assign hready2 = rdy2 & ~hready_block;
    assign hready0 = rdy0 & ~hready_block;
    assign o_rdata = dsel ? rdata0 : rdata2;
    assign o_rdy   = dsel ? rdy0 : rdy2;
    assign o_resp  = dsel ? resp0 : resp2;

    ahb_wait_slave #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready2), .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2)
    );

    ahb_wait_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready0), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] ref_mem [2][256];
    int          ws_of [2] = '{2, 0};

    // Observations of the last xfer call.
    logic [31:0] x_rd;
    logic        x_resp;
    int          x_nlow;
    logic        x_resp_low;
    logic [31:0] x_rd_low;

    function automatic logic ref_err(input logic wr, input logic [31:0] addr,
                                     input logic [2:0] size);
        int unsigned nb;
        if (size > 3'd2) return 1'b1;
        nb = 32'd1 << size;
        if ((addr % nb) != 0) return 1'b1;
        if (wr && (((addr / 4) % 256) >= 240)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wd);
        int nb  = 1 << size;
        int off = int'(addr % 32'd4);
        int idx = int'((addr / 32'd4) % 32'd256);
        for (int k = off; k < off + nb; k++) ref_mem[d][idx][8*k +: 8] = wd[8*k +: 8];
    endtask

    // One non-pipelined transfer; called #1 after a rising edge, returns #1 after the
    // edge that closes the data phase.
    task automatic xfer(input logic d, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd);
        dsel   = d;
        hsel   = 1'b1;
        htrans = 2'd2;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hburst = 3'($urandom_range(0, 7));
        @(posedge HCLK); #1;
        // Scramble address-phase signals so only latched values can be used.
        hsel       = 1'b0;
        htrans     = 2'd0;
        haddr      = $urandom;
        hwrite     = 1'($urandom_range(0, 1));
        hsize      = 3'($urandom_range(0, 7));
        hwdata     = wd;
        x_nlow     = 0;
        x_resp_low = 1'b0;
        x_rd_low   = 32'd0;
        while (o_rdy !== 1'b1 && x_nlow < 40) begin
            x_resp_low = x_resp_low | o_resp;
            x_rd_low   = x_rd_low | o_rdata;
            x_nlow++;
            @(posedge HCLK); #1;
        end
        x_rd   = o_rdata;
        x_resp = o_resp;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        HRESET = 1'b1;
        hsel = 1'b0; dsel = 1'b0; hwrite = 1'b0; hready_block = 1'b0;
        haddr = 32'd0; hwdata = 32'd0; hsize = 3'd0; hburst = 3'd0; htrans = 2'd0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom; u_dut2.DATA_MEM[i] = v; ref_mem[0][i] = v;
            v = $urandom; u_dut0.DATA_MEM[i] = v; ref_mem[1][i] = v;
        end
        repeat (3) @(posedge HCLK);
        #1;
        n_chk++;
        if ({rdy2, resp2, rdata2, rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0})
        begin
            n_err++;
            $display("FAIL reset_outputs: got rdy/resp/rdata %b %b %h, %b %b %h want 1 0 0",
                     rdy2, resp2, rdata2, rdy0, resp0, rdata0);
        end
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Reset asserted mid-wait drops the pending write.
        dsel = 1'b0; hsel = 1'b1; htrans = 2'd2; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = ~ref_mem[0][16];
        n_chk++;
        if (o_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pre_wait: got hreadyout %b want 0", o_rdy);
        end
        HRESET = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if ({o_rdy, o_resp, o_rdata} !== {1'b1, 1'b0, 32'd0}) begin
                n_err++;
                $display("FAIL reset_mid_wait[%0d]: got %b %b %h want 1 0 00000000",
                         c, o_rdy, o_resp, o_rdata);
            end
            @(posedge HCLK); #1;
        end
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        n_chk++;
        if (u_dut2.DATA_MEM[16] !== ref_mem[0][16]) begin
            n_err++;
            $display("FAIL reset_drop_write: got %h want %h", u_dut2.DATA_MEM[16],
                     ref_mem[0][16]);
        end
        xfer(1'b0, 1'b0, 32'h40, 3'd2, 32'd0);
        n_chk++;
        if (x_rd !== ref_mem[0][16] || x_nlow != 2) begin
            n_err++;
            $display("FAIL reset_readback: got %h waits %0d want %h waits 2", x_rd, x_nlow,
                     ref_mem[0][16]);
        end
    endtask

    task automatic test_wait_states();
        xfer(1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        ref_write(0, 32'h10, 3'd2, 32'hDEADBEEF);
        n_chk++;
        if (x_nlow != 2 || x_resp_low !== 1'b0 || x_resp !== 1'b0) begin
            n_err++;
            $display("FAIL wait_write: got waits %0d resp %b/%b want 2 0/0", x_nlow,
                     x_resp_low, x_resp);
        end
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'd0);
        n_chk++;
        if (x_nlow != 2 || x_rd !== 32'hDEADBEEF || x_rd_low !== 32'd0) begin
            n_err++;
            $display("FAIL wait_read: got waits %0d data %h early %h want 2 deadbeef 0",
                     x_nlow, x_rd, x_rd_low);
        end
    endtask

    task automatic test_byte_lanes();
        u_dut2.DATA_MEM[4] = 32'h11223344;
        ref_mem[0][4] = 32'h11223344;
        xfer(1'b0, 1'b1, 32'h13, 3'd0, 32'hAA000000);
        ref_write(0, 32'h13, 3'd0, 32'hAA000000);
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'd0);
        n_chk++;
        if (x_rd !== 32'hAA223344) begin
            n_err++;
            $display("FAIL byte_write: got %h want aa223344", x_rd);
        end
        xfer(1'b0, 1'b1, 32'h10, 3'd1, 32'h00005566);
        ref_write(0, 32'h10, 3'd1, 32'h00005566);
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'd0);
        n_chk++;
        if (x_rd !== 32'hAA225566) begin
            n_err++;
            $display("FAIL half_write: got %h want aa225566", x_rd);
        end
    endtask

    task automatic test_error();
        xfer(1'b0, 1'b1, 32'h3C0, 3'd2, ~ref_mem[0][240]);
        n_chk++;
        if (x_nlow != 1 || x_resp_low !== 1'b1 || x_resp !== 1'b1 || x_rd !== 32'd0) begin
            n_err++;
            $display("FAIL err_ro_write: got low %0d resp %b/%b data %h want 1 1/1 0",
                     x_nlow, x_resp_low, x_resp, x_rd);
        end
        xfer(1'b0, 1'b0, 32'h3C0, 3'd2, 32'd0);
        n_chk++;
        if (x_rd !== ref_mem[0][240] || x_resp !== 1'b0) begin
            n_err++;
            $display("FAIL err_ro_unchanged: got %h resp %b want %h 0", x_rd, x_resp,
                     ref_mem[0][240]);
        end
        xfer(1'b0, 1'b0, 32'h02, 3'd2, 32'd0);
        n_chk++;
        if (x_nlow != 1 || x_resp_low !== 1'b1 || x_resp !== 1'b1 || x_rd !== 32'd0 ||
            x_rd_low !== 32'd0) begin
            n_err++;
            $display("FAIL err_misaligned: got low %0d resp %b/%b data %h want 1 1/1 0",
                     x_nlow, x_resp_low, x_resp, x_rd);
        end
    endtask

    // Pipelined beats on the zero-wait instance: INCR4 write, INCR4 read, then a write
    // followed directly by a read of the same word.
    task automatic test_back_to_back();
        logic [31:0] b_addr [10];
        logic        b_wr   [10];
        logic [31:0] b_wd   [10];
        logic [31:0] exp_rd;
        for (int i = 0; i < 4; i++) begin
            b_addr[i] = 32'h20 + 32'(4 * i); b_wr[i] = 1'b1; b_wd[i] = 32'(i + 1);
            b_addr[i+4] = 32'h20 + 32'(4 * i); b_wr[i+4] = 1'b0; b_wd[i+4] = 32'd0;
        end
        b_addr[8] = 32'h50; b_wr[8] = 1'b1; b_wd[8] = $urandom;
        b_addr[9] = 32'h50; b_wr[9] = 1'b0; b_wd[9] = 32'd0;
        dsel = 1'b1;
        hsize = 3'd2;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                hsel   = 1'b1;
                htrans = (i == 0 || i == 4 || i == 8) ? 2'd2 : 2'd3;
                hburst = (i < 8) ? 3'd3 : 3'd0;
                haddr  = b_addr[i];
                hwrite = b_wr[i];
            end else begin
                hsel = 1'b0; htrans = 2'd0;
            end
            if (i > 0) begin
                hwdata = b_wd[i-1];
                n_chk++;
                if (o_rdy !== 1'b1 || o_resp !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_ready[%0d]: got rdy %b resp %b want 1 0", i - 1, o_rdy,
                             o_resp);
                end
                exp_rd = b_wr[i-1] ? 32'd0 : ref_mem[1][(b_addr[i-1] / 4) % 256];
                n_chk++;
                if (o_rdata !== exp_rd) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", i - 1, o_rdata, exp_rd);
                end
            end
            @(posedge HCLK); #1;
            if (i > 0 && b_wr[i-1]) ref_write(1, b_addr[i-1], 3'd2, b_wd[i-1]);
        end
        n_chk++;
        if (ref_mem[1][8] !== 32'd1 || ref_mem[1][11] !== 32'd4) begin
            n_err++;
            $display("FAIL b2b_model: got %h %h want 1 4", ref_mem[1][8], ref_mem[1][11]);
        end
    endtask

    task automatic test_idle_busy();
        dsel = 1'b0; hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
        hwdata = ~ref_mem[0][4];
        for (int i = 0; i < 4; i++) begin
            htrans = (i < 2) ? 2'd0 : 2'd1;
            @(posedge HCLK); #1;
            n_chk++;
            if ({o_rdy, o_resp, o_rdata} !== {1'b1, 1'b0, 32'd0}) begin
                n_err++;
                $display("FAIL idle_busy[%0d]: got %b %b %h want 1 0 0", i, o_rdy, o_resp,
                         o_rdata);
            end
        end
        htrans = 2'd2;
        hready_block = 1'b1;
        @(posedge HCLK); #1;
        hready_block = 1'b0; hsel = 1'b0; htrans = 2'd0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({o_rdy, o_resp} !== 2'b10) begin
                n_err++;
                $display("FAIL hready_low[%0d]: got rdy %b resp %b want 1 0", i, o_rdy, o_resp);
            end
            @(posedge HCLK); #1;
        end
        n_chk++;
        if (u_dut2.DATA_MEM[4] !== ref_mem[0][4]) begin
            n_err++;
            $display("FAIL idle_no_write: got %h want %h", u_dut2.DATA_MEM[4], ref_mem[0][4]);
        end
    endtask

    task automatic test_random();
        logic        d, wr, err;
        logic [2:0]  size;
        logic [31:0] addr, wd, erd;
        int          idx, off, ew;
        for (int t = 0; t < 80; t++) begin
            d    = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                               : 3'($urandom_range(0, 2));
            off  = (size == 3'd0) ? int'($urandom_range(0, 3)) :
                   (size == 3'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
            case ($urandom_range(0, 3))
                0:       addr = 32'(4 * $urandom_range(0, 239) + off);
                1:       addr = 32'(4 * $urandom_range(240, 255) + off);
                2:       addr = $urandom;
                default: addr = 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
            endcase
            wd  = $urandom;
            idx = int'((addr / 32'd4) % 32'd256);
            err = ref_err(wr, addr, size);
            ew  = err ? 1 : ws_of[d];
            erd = (err || wr) ? 32'd0 : ref_mem[d][idx];
            xfer(d, wr, addr, size, wd);
            n_chk++;
            if (x_nlow != ew || x_resp_low !== err || x_resp !== err || x_rd !== erd ||
                x_rd_low !== 32'd0) begin
                n_err++;
                $display("FAIL rand[%0d] d%0d wr%0d a=%h sz=%0d: got low %0d resp %b/%b data %h early %h want %0d %b/%b %h 0",
                         t, d, wr, addr, size, x_nlow, x_resp_low, x_resp, x_rd, x_rd_low,
                         ew, err, err, erd);
            end
            if (!err && wr) ref_write(int'(d), addr, size, wd);
        end
        for (int d2 = 0; d2 < 2; d2++) begin
            int bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (d2 == 0 && u_dut2.DATA_MEM[i] !== ref_mem[0][i]) bad++;
                if (d2 == 1 && u_dut0.DATA_MEM[i] !== ref_mem[1][i]) bad++;
            end
            n_chk++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL mem_final[%0d]: got %0d differing words want 0", d2, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_byte_lanes();
        test_error();
        test_back_to_back();
        test_idle_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ahb_wait_slave.md
# ahb_wait_slave

AHB-Lite subordinate with a 256-word on-chip memory, a configurable number of wait states, and a two-cycle ERROR response. It is the responder for the existing AHB-Lite master and plugs into the top-level decoder/mux beside the current memory slaves. Its purpose is to exercise the master's HREADY stall and HRESP error paths from a real slave instead of bench-forced flags.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported
- MEM_DEPTH, 256, number of words; power of two
- WAIT_STATES, 1, wait cycles inserted per OKAY data phase; legal range 0..15
- RO_BASE, 8'hF0, first read-only word index; writes at or above it return ERROR

Ports:
- HCLK  in  1  clock, rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select from the decoder
- HADDR  in  ADDR_WIDTH  byte address
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HBURST  in  3  ignored; every beat is handled independently
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus ready from the mux
- HRDATA  out  32  read data
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
**Accept**
- The address phase is accepted on a rising edge when HSEL & HREADY & HTRANS[1] = 1.
- On accept, latch HADDR, HWRITE and HSIZE.
- IDLE/BUSY beats, or HSEL=0, give no data phase. The slave stays in ST_IDLE.

**Error condition**, evaluated at accept:
- HSIZE > 2
- HSIZE = 2 with HADDR[1:0] ≠ 0
- HSIZE = 1 with HADDR[0] ≠ 0
- HWRITE = 1 with word index ≥ RO_BASE

**Addressing**
- Word index = HADDR[log2(MEM_DEPTH)+1:2]. Upper bits are ignored, so addresses alias.
- Memory is the array DATA_MEM[0:MEM_DEPTH-1]. It is not reset and is hierarchically visible for bench preload.

**FSM**
- ST_IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - Accept with error → ST_ERR1.
  - Accept, no error, WAIT_STATES > 0 → ST_WAIT, counter = WAIT_STATES.
  - Accept, no error, WAIT_STATES = 0 → ST_DATA.
- ST_WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; when it reaches 1, go to ST_DATA.
- ST_DATA: HREADYOUT=1, HRESP=0; this is the final data-phase cycle.
  - Read: HRDATA = DATA_MEM[latched index], full word, regardless of HSIZE.
  - Write: at the closing edge, HWDATA byte lanes selected by the latched HSIZE/HADDR[1:0] are written, little-endian (byte k ↔ HWDATA[8k+7:8k]).
  - The same edge may accept a new address phase; next state is chosen exactly as from ST_IDLE.
- ST_ERR1: HREADYOUT=0, HRESP=1 → ST_ERR2.
- ST_ERR2: HREADYOUT=1, HRESP=1. No memory write. HRDATA=0.
  - Next state is chosen as from ST_IDLE; the master normally drives IDLE here.
- Error transfers never insert wait states.
- HRDATA = 0 in every cycle except a read in ST_DATA.

**Reset**
- HRESET asserted at any time, including mid-wait or mid-error: immediately go to ST_IDLE with HREADYOUT=1, HRESP=0, HRDATA=0 and counter=0.
- A write in flight is dropped. Memory contents are unchanged.

## Timing
- OKAY latency: WAIT_STATES+1 data-phase cycles. Back-to-back throughput is one transfer per WAIT_STATES+1 cycles.
- ERROR: exactly two cycles. HRESP rises in the first cycle, before HREADYOUT.
- Write commit happens at the edge ending ST_DATA. A read whose data phase follows a write to the same word returns the new data with no hazard.
- HREADY=0 from another slave: no accept. A stall inside this slave's own data phase is impossible, because HREADY mirrors HREADYOUT when the slave is selected.
- All outputs are registered state decodes, except HRDATA, which is combinational from DATA_MEM and the latched index.

## Test plan
1. Reset: hold HRESET=1 for 3 cycles mid-ST_WAIT → HREADYOUT=1, HRESP=0, HRDATA=0; the pending write leaves DATA_MEM unchanged.
2. WAIT_STATES=2: write word 0xDEADBEEF to 0x10, then read 0x10 → each data phase has HREADYOUT low for 2 cycles, and the read returns 0xDEADBEEF.
3. Preload word 4 = 0x11223344. Byte write 0xAA (HWDATA=0xAA000000) to 0x13 → reading 0x10 returns 0xAA223344. Then halfword write 0x5566 to 0x10 → reading returns 0xAA225566.
4. Write to 0x3C0 (index 0xF0) → HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1, and memory is unchanged. Word read at 0x02 → same two-cycle ERROR.
5. WAIT_STATES=0: 4-beat INCR write (NONSEQ, SEQ×3) of 1..4 to 0x20, then 4-beat read → one beat per cycle, HREADYOUT constantly 1, reads return 1,2,3,4.
6. HSEL=1 with HTRANS=IDLE or BUSY → OKAY, zero wait, no memory change. HTRANS=NONSEQ with HREADY=0 → not accepted; the slave stays in ST_IDLE.
